// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
//
// Purpose: pipelined add/subtract unit. Each pipeline stage resolves one 4-bit
// group with a carry-lookahead adder. The carry out of a group is registered
// and handed to the next stage. The operand bits that are not yet added travel
// down the pipeline with it, and the resolved sum bits accumulate low-to-high.
// The word that leaves the last stage is therefore already bit-aligned.
// Subtraction is a + ~b + 1. The mode is applied when an operand is accepted,
// so every stage after the first sees only b' and the carry.
//
// Parameters:
//   nBITS   operand width; a multiple of 4 and at least 4
//   STAGES  nBITS/4, the pipeline depth (one CLA group per stage)
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   ain, bin   operands (nBITS)
//   cin        carry-in, ignored when sub=1
//   sub        0: ain+bin+cin, 1: ain-bin
//   in_valid   operand valid
//   in_ready   operand accepted this cycle (equals the advance condition)
//   sum        result (nBITS); zero while out_valid=0
//   cout       carry out of the MSB group (for sub=1, 1 means no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   out_valid  result valid
//   out_ready  downstream accepts result
// ---------------------------------------------------------------------------
module pipelined_cla_adder #(
  parameter int nBITS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [nBITS-1:0] ain,
  input  logic [nBITS-1:0] bin,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [nBITS-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = nBITS / 4;

  // 4-bit carry-lookahead group: every carry is a flat sum of products of
  // generate/propagate terms, so no carry ripples through the group.
  // Returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic       ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  // The whole pipeline moves as one unit. It stalls only when a valid result
  // is parked at the output and downstream is not taking it.
  logic advance_s;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      localparam int W_OP  = nBITS - 4*k;  // operand bits still to be added here
      localparam int W_SUM = 4*(k+1);      // result bits resolved after this stage

      logic [W_OP-1:0]  a_in_s;
      logic [W_OP-1:0]  b_in_s;
      logic             c_in_s;
      logic             v_in_s;
      logic [4:0]       cla_s;
      logic [W_SUM-1:0] sum_nx_s;
      logic             vld_r;
      logic             c_r;
      logic [W_SUM-1:0] sum_r;

      if (k == 0) begin : g_head
        // Mode is folded in here, so later stages never look at sub.
        assign a_in_s   = ain;
        assign b_in_s   = sub ? ~bin : bin;
        assign c_in_s   = sub ? 1'b1 : cin;
        assign v_in_s   = in_valid;
        assign sum_nx_s = cla_s[3:0];
      end else begin : g_body
        assign a_in_s   = g_stage[k-1].g_ops.a_r;
        assign b_in_s   = g_stage[k-1].g_ops.b_r;
        assign c_in_s   = g_stage[k-1].c_r;
        assign v_in_s   = g_stage[k-1].vld_r;
        assign sum_nx_s = {cla_s[3:0], g_stage[k-1].sum_r};
      end

      assign cla_s = cla4(a_in_s[3:0], b_in_s[3:0], c_in_s);

      // Stage valid, group carry and partial sum. A bubble loads zeros, so
      // an invalid slot never carries data to the outputs.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_r <= 1'b0;
          c_r   <= 1'b0;
          sum_r <= {W_SUM{1'b0}};
        end else if (advance_s) begin
          if (v_in_s) begin
            vld_r <= 1'b1;
            c_r   <= cla_s[4];
            sum_r <= sum_nx_s;
          end else begin
            vld_r <= 1'b0;
            c_r   <= 1'b0;
            sum_r <= {W_SUM{1'b0}};
          end
        end
      end

      if (k < STAGES-1) begin : g_ops
        logic [W_OP-5:0] a_r;
        logic [W_OP-5:0] b_r;

        // Carry the operand bits of the higher groups forward (input skew).
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            a_r <= {(W_OP-4){1'b0}};
            b_r <= {(W_OP-4){1'b0}};
          end else if (advance_s) begin
            if (v_in_s) begin
              a_r <= a_in_s[W_OP-1:4];
              b_r <= b_in_s[W_OP-1:4];
            end else begin
              a_r <= {(W_OP-4){1'b0}};
              b_r <= {(W_OP-4){1'b0}};
            end
          end
        end
      end

      if (k == STAGES-1) begin : g_tail
        logic ovf_r;

        // Carry into the MSB is recovered as a^b^s at bit 3 of the top group.
        // Overflow is that carry xor the carry out.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            ovf_r <= 1'b0;
          end else if (advance_s) begin
            if (v_in_s) begin
              ovf_r <= a_in_s[3] ^ b_in_s[3] ^ cla_s[3] ^ cla_s[4];
            end else begin
              ovf_r <= 1'b0;
            end
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].vld_r;
  assign sum       = g_stage[STAGES-1].sum_r;
  assign cout      = g_stage[STAGES-1].c_r;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_r;
  assign advance_s = ~out_valid | out_ready;
  assign in_ready  = advance_s;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_cla_adder
//
// Purpose: self-checking bench for pipelined_cla_adder.
// - A 16-bit instance is checked on every cycle against a delay-line model.
//   The model holds arithmetic results, stalls globally and clears on reset.
// - Directed cases pin literal values: carry chain, overflow, streaming,
//   backpressure and mid-stream reset.
// - A 4-bit instance is swept exhaustively.
// ---------------------------------------------------------------------------
module tb_pipelined_cla_adder;

  localparam int N = 16;
  localparam int S = N / 4;

  logic          clk;
  logic          reset_n;
  logic [N-1:0]  ain;
  logic [N-1:0]  bin;
  logic          cin;
  logic          sub;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic          out_valid;
  logic          out_ready;

  logic [3:0]    a4;
  logic [3:0]    b4;
  logic          cin4;
  logic          sub4;
  logic          iv4;
  logic          ir4;
  logic [3:0]    s4;
  logic          co4;
  logic          ov4;
  logic          ovl4;

  int n_checks = 0;
  int n_errors = 0;

  pipelined_cla_adder #(.nBITS(N)) u_dut (
    .clk(clk), .reset_n(reset_n), .ain(ain), .bin(bin), .cin(cin), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  pipelined_cla_adder #(.nBITS(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .ain(a4), .bin(b4), .cin(cin4), .sub(sub4),
    .in_valid(iv4), .in_ready(ir4), .sum(s4), .cout(co4), .ovf(ov4),
    .out_valid(ovl4), .out_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic for width w. Returns {ovf, cout, sum[15:0]}.
  function automatic logic [17:0] ref_add(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci,
                                          input logic sb);
    logic [31:0] mask;
    logic [31:0] bb;
    logic [31:0] full;
    logic        c0;
    logic        co;
    logic        ov;
    mask = (32'd1 << w) - 32'd1;
    bb   = sb ? (~b & mask) : (b & mask);
    c0   = sb ? 1'b1 : ci;
    full = (a & mask) + bb + {31'd0, c0};
    co   = full[w];
    // Signed overflow: both addends share a sign and the result sign differs.
    ov   = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
    return {ov, co, full[15:0] & mask[15:0]};
  endfunction

  typedef struct packed {
    logic         v;
    logic         o;
    logic         c;
    logic [N-1:0] s;
  } slot_t;

  function automatic slot_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic ci, input logic sb, input logic v);
    logic [17:0] r;
    slot_t       t;
    r   = ref_add(N, {16'd0, a}, {16'd0, b}, ci, sb);
    t.v = 1'b1;
    t.o = r[17];
    t.c = r[16];
    t.s = r[15:0];
    if (!v) t = '0;
    return t;
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input slot_t e);
    chk({name, "_valid"}, 32'(out_valid), 32'(e.v));
    chk({name, "_sum"},   32'(sum),       32'(e.s));
    chk({name, "_cout"},  32'(cout),      32'(e.c));
    chk({name, "_ovf"},   32'(ovf),       32'(e.o));
  endtask

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic ci, input logic sb);
    ain = a; bin = b; cin = ci; sub = sb; in_valid = 1'b1;
  endtask

  // Model: S result slots that shift together whenever the output slot is empty or taken.
  slot_t mp [S];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < S; i++) mp[i] <= '0;
    end else if (!mp[S-1].v || out_ready) begin
      mp[0] <= mk(ain, bin, cin, sub, in_valid);
      for (int i = 1; i < S; i++) mp[i] <= mp[i-1];
    end
  end

  // Compare the 16-bit instance with the model on every falling edge.
  always @(negedge clk) begin
    chk_out("model", mp[S-1]);
    chk("model_in_ready", 32'(in_ready), 32'(!mp[S-1].v || out_ready));
  end

  // Accept one operation into an idle pipe. Scramble the inputs afterwards,
  // then check the exact latency and the literal result.
  task automatic run_single(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic ci, input logic sb,
                            input logic [N-1:0] es, input logic ec, input logic eo,
                            input string nm);
    slot_t e;
    @(posedge clk); #1;
    drive(a, b, ci, sb);
    @(posedge clk); #1;
    in_valid = 1'b0; ain = 16'($urandom); bin = 16'($urandom); sub = ~sb; cin = ~ci;
    repeat (S-2) @(posedge clk);
    #1;
    chk({nm, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    e.v = 1'b1; e.s = es; e.c = ec; e.o = eo;
    chk_out(nm, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    slot_t bp [5];
    slot_t e;
    reset_n = 1'b1; ain = '0; bin = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; sub4 = 1'b0; iv4 = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum",       32'(sum),       32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_u4_valid",  32'(ovl4),      32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Carry chain and overflow cases.
    run_single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_chain");
    run_single(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    run_single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    run_single(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "borrow");

    // Streaming: 1+2, 3+4+1, 10-3 back to back.
    @(posedge clk); #1;
    drive(16'd1, 16'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'd3, 16'd4, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(16'd10, 16'd3, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stream_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    e = '0; e.v = 1'b1; e.s = 16'd3;
    chk_out("stream0", e);
    @(posedge clk); #1;
    e = '0; e.v = 1'b1; e.s = 16'd8;
    chk_out("stream1", e);
    @(posedge clk); #1;
    e = '0; e.v = 1'b1; e.s = 16'd7; e.c = 1'b1;
    chk_out("stream2", e);
    @(posedge clk); #1;
    chk("stream_after", 32'(out_valid), 32'd0);

    // Backpressure: fill the pipe, stall for 5 cycles, then drain.
    for (int i = 0; i < 5; i++) begin
      logic [N-1:0] xa;
      logic [N-1:0] xb;
      logic         xc;
      logic         xs;
      xa = pick16(); xb = pick16(); xc = 1'($urandom); xs = 1'($urandom);
      bp[i] = mk(xa, xb, xc, xs, 1'b1);
      @(posedge clk); #1;
      drive(xa, xb, xc, xs);
    end
    // Op 4 is presented now but cannot enter until the stall ends.
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk_out("bp_hold", bp[0]);
      @(posedge clk); #2;
    end
    chk_out("bp_hold_end", bp[0]);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_out("bp_drain", bp[i]);
    end
    @(posedge clk); #1;
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset mid-stream: one result at the output, one more in flight.
    @(posedge clk); #1;
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'h4444, 16'h0001, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    e = '0;
    chk_out("rst_async", e);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #3;
    reset_n = 1'b1;
    drive(16'h1234, 16'h0FED, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (S-2) @(posedge clk);
    #1;
    chk("rst_no_stale", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    e = '0; e.v = 1'b1; e.s = 16'h2221;
    chk_out("rst_first_accept", e);

    // Random traffic with random backpressure, checked by the model.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      ain = pick16(); bin = pick16(); cin = 1'($urandom); sub = 1'($urandom);
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S+2) @(posedge clk);
    #1;
    chk("rand_drained", 32'(out_valid), 32'd0);

    // Exhaustive sweep of the 4-bit instance, one operation per cycle.
    for (int i = 0; i < 1024; i++) begin
      logic [3:0]  xa;
      logic [3:0]  xb;
      logic        xc;
      logic        xs;
      logic [17:0] r;
      xa = 4'(i); xb = 4'(i >> 4); xc = i[8]; xs = i[9];
      a4 = xa; b4 = xb; cin4 = xc; sub4 = xs; iv4 = 1'b1;
      @(posedge clk); #1;
      r = ref_add(4, {28'd0, xa}, {28'd0, xb}, xc, xs);
      chk("u4_valid", 32'(ovl4), 32'd1);
      chk("u4_sum",   32'(s4),   {28'd0, r[3:0]});
      chk("u4_cout",  32'(co4),  32'(r[16]));
      chk("u4_ovf",   32'(ov4),  32'(r[17]));
      chk("u4_ready", 32'(ir4),  32'd1);
    end
    iv4 = 1'b0;
    @(posedge clk); #1;
    chk("u4_bubble_valid", 32'(ovl4), 32'd0);
    chk("u4_bubble_sum",   32'(s4),   32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
